// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data cache memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_RESP = 2'd2
    } state_t;

    localparam logic OWNER_IC = 1'b0;
    localparam logic OWNER_DC = 1'b1;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // Wide enough for the largest legal MAX_WAIT (15).
    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/arb_starve_sel.sv
// Data-cache-first arbitration with a bounded number of consecutive losses
// for the instruction cache before it is forced to win.
module arb_starve_sel
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_arb_en,
    input  logic i_ic_valid,
    input  logic i_dc_valid,
    output logic o_grant_ic,
    output logic o_grant_dc
);

    localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_C = WAIT_CNT_W'(MAX_WAIT);

    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic                  w_dc_win;

    assign w_dc_win   = i_dc_valid && ((r_wait_cnt < MAX_WAIT_C) || !i_ic_valid);
    assign o_grant_dc = i_arb_en && w_dc_win;
    assign o_grant_ic = i_arb_en && i_ic_valid && !w_dc_win;

    // Counts only losses suffered while the icache was actually waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (i_arb_en) begin
            if (!i_ic_valid || o_grant_ic) begin
                r_wait_cnt <= '0;
            end else if (o_grant_dc && (r_wait_cnt < MAX_WAIT_C)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one backing-memory port between icache refills and dcache
// refills/writebacks; one transaction in flight, reads routed back to owner.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  ic_req_valid,
    input  logic [ADDR_WIDTH-1:0] ic_req_addr,
    output logic                  ic_req_ready,
    output logic                  ic_resp_valid,
    output logic [DATA_WIDTH-1:0] ic_resp_data,

    input  logic                  dc_req_valid,
    input  logic                  dc_req_rw,
    input  logic [ADDR_WIDTH-1:0] dc_req_addr,
    input  logic [DATA_WIDTH-1:0] dc_req_data,
    output logic                  dc_req_ready,
    output logic                  dc_resp_valid,
    output logic [DATA_WIDTH-1:0] dc_resp_data,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_rw,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_data,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,

    output logic                  protocol_err
);

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_owner;
    logic                  r_rw;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_ic_resp_valid;
    logic                  r_dc_resp_valid;
    logic [DATA_WIDTH-1:0] r_ic_resp_data;
    logic [DATA_WIDTH-1:0] r_dc_resp_data;
    logic                  r_perr;

    logic                  w_arb_en;
    logic                  w_grant_ic;
    logic                  w_grant_dc;
    logic                  w_resp_hit;

    assign w_arb_en   = (r_state == S_IDLE);
    assign w_resp_hit = (r_state == S_WAIT_RESP) && mem_resp_valid;

    arb_starve_sel #(
        .MAX_WAIT (MAX_WAIT)
    ) u_sel (
        .clk        (clk),
        .reset      (reset),
        .i_arb_en   (w_arb_en),
        .i_ic_valid (ic_req_valid),
        .i_dc_valid (dc_req_valid),
        .o_grant_ic (w_grant_ic),
        .o_grant_dc (w_grant_dc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        ic_req_ready  = 1'b0;
        dc_req_ready  = 1'b0;
        mem_req_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                ic_req_ready = w_grant_ic;
                dc_req_ready = w_grant_dc;
                if (w_grant_ic || w_grant_dc) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    w_state_next = (r_rw == RW_WRITE) ? S_IDLE : S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                if (mem_resp_valid) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Request fields are captured at grant and drive the memory port until handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner <= OWNER_IC;
            r_rw    <= RW_READ;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (w_grant_dc) begin
            r_owner <= OWNER_DC;
            r_rw    <= dc_req_rw;
            r_addr  <= dc_req_addr;
            r_data  <= dc_req_data;
        end else if (w_grant_ic) begin
            r_owner <= OWNER_IC;
            r_rw    <= RW_READ;
            r_addr  <= ic_req_addr;
            r_data  <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ic_resp_valid <= 1'b0;
            r_dc_resp_valid <= 1'b0;
            r_ic_resp_data  <= '0;
            r_dc_resp_data  <= '0;
            r_perr          <= 1'b0;
        end else begin
            r_ic_resp_valid <= w_resp_hit && (r_owner == OWNER_IC);
            r_dc_resp_valid <= w_resp_hit && (r_owner == OWNER_DC);
            if (w_resp_hit && (r_owner == OWNER_IC)) begin
                r_ic_resp_data <= mem_resp_data;
            end
            if (w_resp_hit && (r_owner == OWNER_DC)) begin
                r_dc_resp_data <= mem_resp_data;
            end
            // Any response outside WAIT_RESP is stray and latches the error.
            if (mem_resp_valid && (r_state != S_WAIT_RESP)) begin
                r_perr <= 1'b1;
            end
        end
    end

    assign mem_req_rw    = r_rw;
    assign mem_req_addr  = r_addr;
    assign mem_req_data  = r_data;
    assign ic_resp_valid = r_ic_resp_valid;
    assign dc_resp_valid = r_dc_resp_valid;
    assign ic_resp_data  = r_ic_resp_data;
    assign dc_resp_data  = r_dc_resp_data;
    assign protocol_err  = r_perr;

endmodule
